// File: rtl/ps2kb_command_scheduler_pkg.sv
// rtl/ps2kb_command_scheduler_pkg.sv - shared types and constants for the PS/2 keyboard command scheduler
package ps2kb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    WAIT_RESP,
    COMPLETE
  } ps2kb_sched_state_t;

  localparam logic [1:0] STAT_ACK         = 2'b00;
  localparam logic [1:0] STAT_RESEND_FAIL = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT     = 2'b10;

  localparam logic [7:0] KB_ACK    = 8'hFA;
  localparam logic [7:0] KB_RESEND = 8'hFE;

endpackage

// File: rtl/ps2kb_command_scheduler_if.sv
// rtl/ps2kb_command_scheduler_if.sv - requester, transmitter, receiver and completion signals of the scheduler
interface ps2kb_command_scheduler_if;

  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_request;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       done;
  logic       done_id;
  logic [1:0] status;
  logic       busy;

  // slave is the scheduler; master is whatever surrounds it
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy, rx_valid, rx_data,
    output req0_ready, req1_ready, tx_request, tx_data, done, done_id, status, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy, rx_valid, rx_data,
    input  req0_ready, req1_ready, tx_request, tx_data, done, done_id, status, busy
  );

endinterface

// File: rtl/ps2kb_command_scheduler_tick_sync.sv
// rtl/ps2kb_command_scheduler_tick_sync.sv - 2-flop synchronizer and registered rising-edge detector
module ps2kb_tick_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
      tick  <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/ps2kb_command_scheduler.sv
// rtl/ps2kb_command_scheduler.sv - arbitrates two requesters onto the PS/2 transmitter with resend retry and timeout
module ps2kb_command_scheduler
  import ps2kb_sched_pkg::*;
#(
  parameter logic [15:0] RESPONSE_TIMEOUT = 16'd2000,
  parameter logic [1:0]  MAX_RETRY        = 2'd2
) (
  input  logic clock,
  input  logic reset,
  input  logic peripheral_clock,
  ps2kb_command_scheduler_if.slave bus
);

  ps2kb_sched_state_t state;
  logic [15:0]        timer;
  logic [1:0]         retry_cnt;
  logic               owner;
  logic               last_grant;
  logic [1:0]         result;
  logic               tick;
  logic               timed_out;
  logic               grant0;
  logic               grant1;

  ps2kb_tick_sync u_tick_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (peripheral_clock),
    .tick     (tick)
  );

  assign timed_out = (timer == RESPONSE_TIMEOUT);

  // On a tie the requester that did not win last time is served
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!bus.tx_busy) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= 16'd0;
      retry_cnt      <= 2'd0;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      result         <= STAT_ACK;
      bus.req0_ready <= 1'b0;
      bus.req1_ready <= 1'b0;
      bus.tx_request <= 1'b0;
      bus.tx_data    <= 8'h00;
      bus.done       <= 1'b0;
      bus.done_id    <= 1'b0;
      bus.status     <= STAT_ACK;
      bus.busy       <= 1'b0;
    end else begin
      bus.req0_ready <= 1'b0;
      bus.req1_ready <= 1'b0;
      bus.done       <= 1'b0;
      if (tick) timer <= timer + 16'd1;

      // every branch that changes state also clears the timer
      case (state)
        IDLE: begin
          timer <= 16'd0;
          if (grant0 || grant1) begin
            bus.tx_data    <= grant1 ? bus.req1_data : bus.req0_data;
            owner          <= grant1;
            last_grant     <= grant1;
            bus.req0_ready <= grant0;
            bus.req1_ready <= grant1;
            retry_cnt      <= 2'd0;
            bus.tx_request <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.tx_busy) begin
            bus.tx_request <= 1'b0;
            timer          <= 16'd0;
            state          <= WAIT_DONE;
          end else if (timed_out) begin
            bus.tx_request <= 1'b0;
            result         <= STAT_TIMEOUT;
            timer          <= 16'd0;
            state          <= COMPLETE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            timer <= 16'd0;
            state <= WAIT_RESP;
          end else if (timed_out) begin
            result <= STAT_TIMEOUT;
            timer  <= 16'd0;
            state  <= COMPLETE;
          end
        end
        WAIT_RESP: begin
          if (bus.rx_valid && bus.rx_data == KB_ACK) begin
            result <= STAT_ACK;
            timer  <= 16'd0;
            state  <= COMPLETE;
          end else if (bus.rx_valid && bus.rx_data == KB_RESEND) begin
            timer <= 16'd0;
            if (retry_cnt < MAX_RETRY) begin
              retry_cnt      <= retry_cnt + 2'd1;
              bus.tx_request <= 1'b1;
              state          <= ISSUE;
            end else begin
              result <= STAT_RESEND_FAIL;
              state  <= COMPLETE;
            end
          end else if (timed_out) begin
            result <= STAT_TIMEOUT;
            timer  <= 16'd0;
            state  <= COMPLETE;
          end
        end
        COMPLETE: begin
          bus.done    <= 1'b1;
          bus.done_id <= owner;
          bus.status  <= result;
          bus.busy    <= 1'b0;
          timer       <= 16'd0;
          state       <= IDLE;
        end
        default: begin
          bus.tx_request <= 1'b0;
          bus.busy       <= 1'b0;
          timer          <= 16'd0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2kb_command_scheduler.sv
// tb/tb_ps2kb_command_scheduler.sv - scoreboard bench with a keyboard/transmitter model for the command scheduler
module tb_ps2kb_command_scheduler;
  import ps2kb_sched_pkg::*;

  localparam logic [15:0] TO   = 16'd8;
  localparam int          MAXR = 2;
  localparam int          TIE  = -3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic peripheral_clock = 1'b0;

  ps2kb_command_scheduler_if ifc ();

  ps2kb_command_scheduler #(
    .RESPONSE_TIMEOUT (TO),
    .MAX_RETRY        (2'(MAXR))
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .peripheral_clock (peripheral_clock),
    .bus              (ifc)
  );

  always #5 clock = ~clock;
  always #97 peripheral_clock = ~peripheral_clock;

  int errors = 0;
  int checks = 0;
  int pclk_edges = 0;
  int pclk_at_busy_fall = 0;
  int pclk_at_done = 0;
  int model_last = 1;
  int busy_len = 50;
  bit busy_never = 1'b0;
  bit send_junk = 1'b0;

  logic [7:0] exp_tx[$];
  int         exp_grant[$];
  logic [2:0] exp_done[$];
  int         attempt_q[$];

  always @(posedge peripheral_clock) pclk_edges++;

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each attempt consumes one keyboard answer; ACK ends well, RESEND retries until
  // the budget is spent, anything else (junk or silence) ends in a timeout.
  function automatic void model_txn(input int r[3], output int issues, output logic [1:0] st);
    issues = 0;
    st = STAT_TIMEOUT;
    for (int k = 0; k <= MAXR; k++) begin
      issues = k + 1;
      if (r[k] == 'hFA || r[k] == TIE) begin st = STAT_ACK; return; end
      if (r[k] != 'hFE) begin st = STAT_TIMEOUT; return; end
      if (k == MAXR) begin st = STAT_RESEND_FAIL; return; end
    end
  endfunction

  // Scoreboard monitor: grants, transmit issues, completions
  initial begin : monitor
    logic prev_req;
    int   act;
    prev_req = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (ifc.tx_request && !prev_req) begin
          if (exp_tx.size() == 0) fail("tx_issue", $sformatf("unexpected issue of 0x%0h", ifc.tx_data));
          else check("tx_data", ifc.tx_data, exp_tx.pop_front());
        end
        if (ifc.req0_ready || ifc.req1_ready) begin
          act = (ifc.req0_ready && ifc.req1_ready) ? 2 : int'(ifc.req1_ready);
          if (exp_grant.size() == 0) fail("grant", $sformatf("unexpected grant %0d", act));
          else check("grant_id", act, exp_grant.pop_front());
        end
        if (ifc.done) begin
          pclk_at_done = pclk_edges;
          act = int'({ifc.done_id, ifc.status});
          if (exp_done.size() == 0) fail("done", $sformatf("unexpected done id/status 0x%0h", act));
          else check("done_id_status", act, int'(exp_done.pop_front()));
        end
      end
      prev_req = ifc.tx_request;
    end
  end

  // Transmitter + keyboard model: answers each issue with the next scripted response
  initial begin : kb_model
    int   r;
    logic prev;
    ifc.tx_busy  = 1'b0;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (ifc.tx_request && !prev && !reset) begin
        r = (attempt_q.size() != 0) ? attempt_q.pop_front() : -1;
        if (busy_never) begin
          prev = 1'b1;
        end else begin
          repeat (2) @(negedge clock);
          ifc.tx_busy = 1'b1;
          repeat (busy_len) @(negedge clock);
          ifc.tx_busy = 1'b0;
          pclk_at_busy_fall = pclk_edges;
          repeat (5) @(negedge clock);
          if (send_junk) begin
            ifc.rx_data = 8'h1C; ifc.rx_valid = 1'b1;
            @(negedge clock);
            ifc.rx_valid = 1'b0;
            repeat (3) @(negedge clock);
          end
          if (r == TIE) begin
            for (int k = 0; k < 3000 && !(dut.state == WAIT_RESP && dut.timer == TO); k++)
              @(negedge clock);
          end
          if (r >= 0 || r == TIE) begin
            ifc.rx_data  = (r == TIE) ? 8'hFA : 8'(r);
            ifc.rx_valid = 1'b1;
            @(negedge clock);
            ifc.rx_valid = 1'b0;
          end
          prev = 1'b0;
        end
      end else begin
        prev = ifc.tx_request;
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!(ifc.req0_ready || ifc.req1_ready) && k < 200) begin @(negedge clock); k++; end
    if (k >= 200) fail("ready_wait", "no ready pulse within 200 cycles");
  endtask

  task automatic wait_done();
    int k = 0;
    while (!ifc.done && k < 3000) begin @(negedge clock); k++; end
    if (k >= 3000) fail("done_wait", "no done pulse within 3000 cycles");
  endtask

  task automatic do_txn(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                        input int r0, input int r1, input int r2);
    int r[3];
    int issues;
    int id;
    logic [1:0] st;
    r = '{r0, r1, r2};
    id = (v0 && v1) ? ((model_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
    model_last = id;
    model_txn(r, issues, st);
    exp_grant.push_back(id);
    for (int i = 0; i < issues; i++) begin
      exp_tx.push_back(id ? d1 : d0);
      attempt_q.push_back(r[i]);
    end
    exp_done.push_back({id[0], st});
    ifc.req0_valid = v0; ifc.req0_data = d0;
    ifc.req1_valid = v1; ifc.req1_data = d1;
    wait_ready();
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_values();
    check("rst_tx_request", ifc.tx_request, 0);
    check("rst_tx_data", ifc.tx_data, 0);
    check("rst_ready", {ifc.req1_ready, ifc.req0_ready}, 0);
    check("rst_done", ifc.done, 0);
    check("rst_done_id", ifc.done_id, 0);
    check("rst_status", ifc.status, 0);
    check("rst_busy", ifc.busy, 0);
  endtask

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stimulus
    int diff, k, x, sel;
    int rr[3];
    ifc.req0_valid = 1'b0; ifc.req0_data = 8'h00;
    ifc.req1_valid = 1'b0; ifc.req1_data = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b0;
    repeat (3) @(negedge clock);

    repeat (4) do_txn(1, 1, 8'hF4, 8'h05, 'hFA, -1, -1);
    do_txn(1, 0, 8'hED, 8'h00, 'hFA, -1, -1);
    do_txn(1, 0, 8'hFF, 8'h00, 'hFE, 'hFE, 'hFA);
    do_txn(0, 1, 8'h00, 8'h12, 'hFE, 'hFE, 'hFE);

    send_junk = 1'b1;
    do_txn(1, 0, 8'hF2, 8'h00, -1, -1, -1);
    send_junk = 1'b0;
    diff = pclk_at_done - pclk_at_busy_fall;
    checks++;
    if (diff < 7 || diff > 9) begin
      errors++;
      $display("FAIL timeout_ticks: got %0d peripheral edges, expected 7..9", diff);
    end

    busy_never = 1'b1;
    do_txn(0, 1, 8'h00, 8'hF3, -1, -1, -1);
    busy_never = 1'b0;

    // abort in WAIT_DONE: no completion expected
    exp_grant.push_back(0);
    exp_tx.push_back(8'hED);
    attempt_q.push_back(-1);
    ifc.req0_valid = 1'b1; ifc.req0_data = 8'hED;
    wait_ready();
    ifc.req0_valid = 1'b0;
    k = 0;
    while (!ifc.tx_busy && k < 100) begin @(negedge clock); k++; end
    if (k >= 100) fail("busy_wait", "transmitter never went busy");
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_values();
    model_last = 1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    k = 0;
    while (ifc.tx_busy && k < 200) begin @(negedge clock); k++; end
    repeat (20) @(negedge clock);

    do_txn(0, 1, 8'h00, 8'hEE, 'hFA, -1, -1);
    do_txn(1, 0, 8'hF0, 8'h00, TIE, -1, -1);

    for (int n = 0; n < 20; n++) begin
      for (int a = 0; a < 3; a++) begin
        x = $urandom_range(0, 9);
        rr[a] = (x < 5) ? 'hFA : (x < 8) ? 'hFE : (x == 8) ? 'h33 : -1;
      end
      sel = $urandom_range(1, 3);
      busy_len = $urandom_range(2, 40);
      do_txn(sel[0], sel[1], 8'($urandom), 8'($urandom), rr[0], rr[1], rr[2]);
    end

    repeat (10) @(negedge clock);
    check("exp_tx_left", exp_tx.size(), 0);
    check("exp_grant_left", exp_grant.size(), 0);
    check("exp_done_left", exp_done.size(), 0);
    check("attempts_left", attempt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
